// File: rtl/make_turn_smart.sv
// Move generator for an M x N, K-in-a-row board: WIN > BLOCK > FREE, one cell scanned per cycle.
// Optional MAKE_TURN_CENTER_FIRST_EN: the FREE pass tries the centre cell first.
module make_turn_smart #(
    parameter  int ROWS    = 3,
    parameter  int COLS    = 3,
    parameter  int WIN_LEN = 3,
    localparam int N       = ROWS * COLS,
    localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          ready,
    input  logic          target_a,
    input  logic [N-1:0]  board_a,
    input  logic [N-1:0]  board_b,
    output logic [N-1:0]  board_a_out,
    output logic [N-1:0]  board_b_out,
    output logic [IW-1:0] move_idx,
    output logic [1:0]    move_kind,
    output logic          valid,
    output logic          error
);

    typedef enum logic [2:0] {S_IDLE, S_WIN, S_BLOCK, S_FREE, S_CENTER, S_EMIT} state_t;
    typedef enum logic [1:0] {K_WIN, K_BLOCK, K_FREE, K_ERROR} kind_t;

`ifdef MAKE_TURN_CENTER_FIRST_EN
    localparam int CENTER = (ROWS / 2) * COLS + COLS / 2;
`endif

    // Off-board coordinates read as empty, so directions that do not fit never match.
    function automatic logic cell_at(input logic [N-1:0] b, input int r, input int c);
        if (r >= 0 && r < ROWS && c >= 0 && c < COLS)
            return b[IW'(r * COLS + c)];
        return 1'b0;
    endfunction

    function automatic logic has_line(input logic [N-1:0] b);
        logic found;
        logic run;
        int   dr;
        int   dc;
        found = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                for (int d = 0; d < 4; d++) begin
                    dr  = (d == 0) ? 0 : 1;
                    dc  = (d == 0 || d == 2) ? 1 : ((d == 1) ? 0 : -1);
                    run = 1'b1;
                    for (int k = 0; k < WIN_LEN; k++)
                        run = run & cell_at(b, r + k * dr, c + k * dc);
                    found = found | run;
                end
            end
        end
        return found;
    endfunction

    state_t        r_state, w_state_next;
    logic [IW-1:0] r_pt, w_pt_next;
    logic [N-1:0]  r_own, w_own_next;
    logic [N-1:0]  r_opp, w_opp_next;
    logic          r_tgt, w_tgt_next;
    logic          r_busy, w_busy_next;
    logic [IW-1:0] r_idx, w_idx_next;
    kind_t         r_kind, w_kind_next;
    logic [N-1:0]  r_a_out, w_a_out_next;
    logic [N-1:0]  r_b_out, w_b_out_next;
    logic [IW-1:0] r_move_idx, w_move_idx_next;
    logic [1:0]    r_move_kind, w_move_kind_next;
    logic          r_valid, w_valid_next;
    logic          r_error, w_error_next;

    logic [N-1:0]  w_pt_bit;
    logic          w_empty;
    logic          w_last;

    assign w_pt_bit = N'(1) << r_pt;
    assign w_empty  = !(r_own[r_pt] | r_opp[r_pt]);
    assign w_last   = (r_pt == IW'(N - 1));

    always_comb begin
        // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
        w_state_next     = r_state;
        w_pt_next        = r_pt;
        w_own_next       = r_own;
        w_opp_next       = r_opp;
        w_tgt_next       = r_tgt;
        w_busy_next      = r_busy;
        w_idx_next       = r_idx;
        w_kind_next      = r_kind;
        w_a_out_next     = r_a_out;
        w_b_out_next     = r_b_out;
        w_move_idx_next  = r_move_idx;
        w_move_kind_next = r_move_kind;
        w_valid_next     = 1'b0;
        w_error_next     = r_error;

        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_own_next  = target_a ? board_a : board_b;
                    w_opp_next  = target_a ? board_b : board_a;
                    w_tgt_next  = target_a;
                    w_busy_next = 1'b1;
                    w_pt_next   = '0;
                    if (|(board_a & board_b)) begin
                        w_idx_next   = '0;
                        w_kind_next  = K_ERROR;
                        w_state_next = S_EMIT;
                    end else begin
                        w_state_next = S_WIN;
                    end
                end else begin
                    w_busy_next = 1'b0;
                end
            end
            S_WIN: begin
                if (w_empty && has_line(r_own | w_pt_bit)) begin
                    w_own_next   = r_own | w_pt_bit;
                    w_idx_next   = r_pt;
                    w_kind_next  = K_WIN;
                    w_state_next = S_EMIT;
                end else if (w_last) begin
                    w_pt_next    = '0;
                    w_state_next = S_BLOCK;
                end else begin
                    w_pt_next = r_pt + IW'(1);
                end
            end
            S_BLOCK: begin
                if (w_empty && has_line(r_opp | w_pt_bit)) begin
                    w_own_next   = r_own | w_pt_bit;
                    w_idx_next   = r_pt;
                    w_kind_next  = K_BLOCK;
                    w_state_next = S_EMIT;
                end else if (w_last) begin
                    w_pt_next = '0;
`ifdef MAKE_TURN_CENTER_FIRST_EN
                    w_state_next = S_CENTER;
`else
                    w_state_next = S_FREE;
`endif
                end else begin
                    w_pt_next = r_pt + IW'(1);
                end
            end
`ifdef MAKE_TURN_CENTER_FIRST_EN
            S_CENTER: begin
                if (!(r_own[CENTER] | r_opp[CENTER])) begin
                    w_own_next   = r_own | (N'(1) << CENTER);
                    w_idx_next   = IW'(CENTER);
                    w_kind_next  = K_FREE;
                    w_state_next = S_EMIT;
                end else begin
                    w_state_next = S_FREE;
                end
            end
`endif
            S_FREE: begin
                if (w_empty) begin
                    w_own_next   = r_own | w_pt_bit;
                    w_idx_next   = r_pt;
                    w_kind_next  = K_FREE;
                    w_state_next = S_EMIT;
                end else if (w_last) begin
                    w_pt_next    = '0;
                    w_idx_next   = '0;
                    w_kind_next  = K_ERROR;
                    w_state_next = S_EMIT;
                end else begin
                    w_pt_next = r_pt + IW'(1);
                end
            end
            S_EMIT: begin
                w_a_out_next     = r_tgt ? r_own : r_opp;
                w_b_out_next     = r_tgt ? r_opp : r_own;
                w_move_idx_next  = r_idx;
                w_move_kind_next = r_kind;
                w_valid_next     = 1'b1;
                w_error_next     = (r_kind == K_ERROR);
                w_busy_next      = 1'b0;
                w_state_next     = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state     <= S_IDLE;
            r_pt        <= '0;
            r_own       <= '0;
            r_opp       <= '0;
            r_tgt       <= 1'b0;
            r_busy      <= 1'b1;
            r_idx       <= '0;
            r_kind      <= K_WIN;
            r_a_out     <= '0;
            r_b_out     <= '0;
            r_move_idx  <= '0;
            r_move_kind <= '0;
            r_valid     <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pt        <= w_pt_next;
            r_own       <= w_own_next;
            r_opp       <= w_opp_next;
            r_tgt       <= w_tgt_next;
            r_busy      <= w_busy_next;
            r_idx       <= w_idx_next;
            r_kind      <= w_kind_next;
            r_a_out     <= w_a_out_next;
            r_b_out     <= w_b_out_next;
            r_move_idx  <= w_move_idx_next;
            r_move_kind <= w_move_kind_next;
            r_valid     <= w_valid_next;
            r_error     <= w_error_next;
        end
    end

    assign ready       = !req && !r_busy;
    assign board_a_out = r_a_out;
    assign board_b_out = r_b_out;
    assign move_idx    = r_move_idx;
    assign move_kind   = r_move_kind;
    assign valid       = r_valid;
    assign error       = r_error;

endmodule

// File: tb/tb_make_turn_smart.sv
// Scoreboard bench for make_turn_smart: a 3x3/K=3 instance and a 4x4/K=3 instance.
module tb_make_turn_smart;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  idx;
        logic [1:0]  kind;
        logic        err;
        logic [7:0]  lat;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       req3 = 1'b0, tgt3 = 1'b0, ready3, valid3, err3;
    logic [8:0] a3 = '0, b3 = '0, a3o, b3o;
    logic [3:0] idx3;
    logic [1:0] kind3;

    logic        req4 = 1'b0, tgt4 = 1'b0, ready4, valid4, err4;
    logic [15:0] a4 = '0, b4 = '0, a4o, b4o;
    logic [3:0]  idx4;
    logic [1:0]  kind4;

    make_turn_smart dut3 (
        .clk(clk), .reset(reset), .req(req3), .ready(ready3), .target_a(tgt3),
        .board_a(a3), .board_b(b3), .board_a_out(a3o), .board_b_out(b3o),
        .move_idx(idx3), .move_kind(kind3), .valid(valid3), .error(err3)
    );

    make_turn_smart #(.ROWS(4), .COLS(4), .WIN_LEN(3)) dut4 (
        .clk(clk), .reset(reset), .req(req4), .ready(ready4), .target_a(tgt4),
        .board_a(a4), .board_b(b4), .board_a_out(a4o), .board_b_out(b4o),
        .move_idx(idx4), .move_kind(kind4), .valid(valid4), .error(err4)
    );

    function automatic string fmt(input res_t x);
        return $sformatf("a=%h b=%h idx=%0d kind=%0d err=%b lat=%0d",
                         x.a, x.b, x.idx, x.kind, x.err, x.lat);
    endfunction

    // Issue one request (sel=0: 3x3, sel=1: 4x4) and wait for the valid pulse.
    task automatic run(input bit sel, input logic [15:0] a, input logic [15:0] b,
                       input logic tgt, input int budget, output res_t r, output bit to);
        to = 1'b1;
        r  = '0;
        @(negedge clk);
        if (!sel) begin req3 = 1'b1; a3 = a[8:0]; b3 = b[8:0]; tgt3 = tgt; end
        else      begin req4 = 1'b1; a4 = a;      b4 = b;      tgt4 = tgt; end
        for (int cnt = 1; cnt <= budget; cnt++) begin
            @(negedge clk);
            req3 = 1'b0;
            req4 = 1'b0;
            if (sel ? valid4 : valid3) begin
                if (!sel) r = '{a: {7'b0, a3o}, b: {7'b0, b3o}, idx: idx3, kind: kind3, err: err3, lat: 8'(cnt)};
                else      r = '{a: a4o, b: b4o, idx: idx4, kind: kind4, err: err4, lat: 8'(cnt)};
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a3o, b3o, idx3, kind3, valid3, err3} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got a=%h b=%h idx=%0d kind=%0d v=%b e=%b, want all 0",
                     a3o, b3o, idx3, kind3, valid3, err3);
        end
        checks++;
        if (ready3 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready3); end
        reset = 1'b0;
        #1;
        checks++;
        if (ready3 !== 1'b0) begin errors++; $display("FAIL post_reset_busy: ready got %b want 0", ready3); end
        @(negedge clk);
        checks++;
        if (ready3 !== 1'b1 || ready4 !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got %b/%b want 1/1", ready3, ready4);
        end
    endtask

    task automatic test_free_empty();
        res_t r, e;
        bit   to;
`ifdef MAKE_TURN_CENTER_FIRST_EN
        sb.push_back('{a: 16'h0010, b: 16'h0000, idx: 4'd4, kind: 2'd2, err: 1'b0, lat: 8'd21});
`else
        sb.push_back('{a: 16'h0001, b: 16'h0000, idx: 4'd0, kind: 2'd2, err: 1'b0, lat: 8'd21});
`endif
        run(1'b0, 16'h0000, 16'h0000, 1'b1, 60, r, to);
        e = sb.pop_front();
        checks++;
        if (to || r !== e) begin errors++; $display("FAIL free_empty: got %s timeout=%b, want %s", fmt(r), to, fmt(e)); end
    endtask

    task automatic test_win();
        res_t r, e;
        bit   to;
        sb.push_back('{a: 16'h0007, b: 16'h0018, idx: 4'd2, kind: 2'd0, err: 1'b0, lat: 8'd5});
        run(1'b0, 16'h0003, 16'h0018, 1'b1, 60, r, to);
        e = sb.pop_front();
        checks++;
        if (to || r !== e) begin errors++; $display("FAIL win_row: got %s timeout=%b, want %s", fmt(r), to, fmt(e)); end
    endtask

    task automatic test_block();
        res_t r, e;
        bit   to;
        sb.push_back('{a: 16'h0021, b: 16'h0018, idx: 4'd5, kind: 2'd1, err: 1'b0, lat: 8'd17});
        run(1'b0, 16'h0001, 16'h0018, 1'b1, 60, r, to);
        e = sb.pop_front();
        checks++;
        if (to || r !== e) begin errors++; $display("FAIL block_a: got %s timeout=%b, want %s", fmt(r), to, fmt(e)); end
        sb.push_back('{a: 16'h0001, b: 16'h0038, idx: 4'd5, kind: 2'd0, err: 1'b0, lat: 8'd8});
        run(1'b0, 16'h0001, 16'h0018, 1'b0, 60, r, to);
        e = sb.pop_front();
        checks++;
        if (to || r !== e) begin errors++; $display("FAIL win_b: got %s timeout=%b, want %s", fmt(r), to, fmt(e)); end
    endtask

    task automatic test_error();
        res_t r, e;
        bit   to;
`ifdef MAKE_TURN_CENTER_FIRST_EN
        sb.push_back('{a: 16'h0155, b: 16'h00AA, idx: 4'd0, kind: 2'd3, err: 1'b1, lat: 8'd30});
`else
        sb.push_back('{a: 16'h0155, b: 16'h00AA, idx: 4'd0, kind: 2'd3, err: 1'b1, lat: 8'd29});
`endif
        run(1'b0, 16'h0155, 16'h00AA, 1'b1, 60, r, to);
        e = sb.pop_front();
        checks++;
        if (to || r !== e) begin errors++; $display("FAIL full_board: got %s timeout=%b, want %s", fmt(r), to, fmt(e)); end
        sb.push_back('{a: 16'h0001, b: 16'h0001, idx: 4'd0, kind: 2'd3, err: 1'b1, lat: 8'd2});
        run(1'b0, 16'h0001, 16'h0001, 1'b1, 60, r, to);
        e = sb.pop_front();
        checks++;
        if (to || r !== e) begin errors++; $display("FAIL overlap: got %s timeout=%b, want %s", fmt(r), to, fmt(e)); end
    endtask

    task automatic test_busy_req();
        res_t r, e;
        int   pulses;
        pulses = 0;
        r      = '0;
        sb.push_back('{a: 16'h0007, b: 16'h0018, idx: 4'd2, kind: 2'd0, err: 1'b0, lat: 8'd5});
        @(negedge clk);
        req3 = 1'b1; a3 = 9'h003; b3 = 9'h018; tgt3 = 1'b1;
        for (int cnt = 1; cnt <= 40; cnt++) begin
            @(negedge clk);
            req3 = (cnt == 2 || cnt == 3);
            #1;
            if (cnt == 1) begin
                checks++;
                if (ready3 !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b want 0", ready3); end
            end
            if (valid3) begin
                pulses++;
                if (pulses == 1)
                    r = '{a: {7'b0, a3o}, b: {7'b0, b3o}, idx: idx3, kind: kind3, err: err3, lat: 8'(cnt)};
            end
        end
        req3 = 1'b0;
        e = sb.pop_front();
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL busy_pulses: got %0d want 1", pulses); end
        checks++;
        if (r !== e) begin errors++; $display("FAIL busy_result: got %s, want %s", fmt(r), fmt(e)); end
    endtask

    task automatic test_reset_mid_scan();
        int pulses;
        pulses = 0;
        @(negedge clk);
        req3 = 1'b1; a3 = 9'h000; b3 = 9'h000; tgt3 = 1'b1;
        @(negedge clk);
        req3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({a3o, b3o, idx3, kind3, valid3, err3} !== '0) begin
            errors++;
            $display("FAIL midscan_outputs: got a=%h b=%h idx=%0d kind=%0d v=%b e=%b, want all 0",
                     a3o, b3o, idx3, kind3, valid3, err3);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ready3 !== 1'b0) begin errors++; $display("FAIL midscan_busy: ready got %b want 0", ready3); end
        @(negedge clk);
        checks++;
        if (ready3 !== 1'b1) begin errors++; $display("FAIL midscan_ready: got %b want 1", ready3); end
        for (int cnt = 0; cnt < 30; cnt++) begin
            @(negedge clk);
            if (valid3) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL midscan_valid: got %0d pulses want 0", pulses); end
    endtask

    task automatic test_4x4();
        res_t r, e;
        bit   to;
        sb.push_back('{a: 16'h0421, b: 16'h0002, idx: 4'd10, kind: 2'd0, err: 1'b0, lat: 8'd13});
        run(1'b1, 16'h0021, 16'h0002, 1'b1, 80, r, to);
        e = sb.pop_front();
        checks++;
        if (to || r !== e) begin errors++; $display("FAIL diag_4x4: got %s timeout=%b, want %s", fmt(r), to, fmt(e)); end
    endtask

    initial begin
        test_reset();
        test_free_empty();
        test_win();
        test_block();
        test_error();
        test_busy_req();
        test_reset_mid_scan();
        test_4x4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
